// File: rtl/branch_predict_unit_if.sv
// branch_predict_unit_if
// Bundles the IF-stage lookup and the EX-stage resolution signals of
// branch_predict_unit. The pipeline side uses the master modport; the
// predictor itself uses the slave modport.
interface branch_predict_unit_if #(
   parameter int PC_W = 9
);
   // IF-stage lookup
   logic [PC_W-1:0] if_pc;
   logic            pred_taken;
   logic [31:0]     pred_target;

   // EX-stage resolution inputs
   logic            ex_valid;
   logic [PC_W-1:0] ex_pc;
   logic [31:0]     imm;
   logic            branch;
   logic [31:0]     alu_result;
   logic            jal;
   logic            jalr_sel;
   logic            halt;
   logic            ex_pred_taken;
   logic [31:0]     ex_pred_target;

   // EX-stage resolution outputs
   logic [31:0]     pc_imm;
   logic [31:0]     pc_four;
   logic [31:0]     br_pc;
   logic            pc_sel;
   logic            flush;
   logic            halted;

   modport master (
      output if_pc, ex_valid, ex_pc, imm, branch, alu_result, jal, jalr_sel,
             halt, ex_pred_taken, ex_pred_target,
      input  pred_taken, pred_target, pc_imm, pc_four, br_pc, pc_sel, flush,
             halted
   );

   modport slave (
      input  if_pc, ex_valid, ex_pc, imm, branch, alu_result, jal, jalr_sel,
             halt, ex_pred_taken, ex_pred_target,
      output pred_taken, pred_target, pc_imm, pc_four, br_pc, pc_sel, flush,
             halted
   );
endinterface

// File: rtl/branch_predict_unit.sv
// branch_predict_unit
// EX-stage branch resolver with an optional direct-mapped BTB of saturating
// counters feeding an IF-stage prediction. A redirect/flush is raised only
// when the resolved outcome disagrees with the prediction carried down the
// pipeline. A halt instruction enters a sticky HALTED state that keeps
// redirecting to the halt PC until reset.
//
// Build option: define BRANCH_PREDICT_EN to build the BTB. Without it the
// unit predicts static not-taken and ignores the carried prediction.
module branch_predict_unit #(
   parameter int PC_W      = 9,
   parameter int BTB_DEPTH = 8,
   parameter int CTR_W     = 2
) (
   input logic                  clk,
   input logic                  reset,   // synchronous, active-low
   branch_predict_unit_if.slave bp
);

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } state_t;

   state_t          state_q, state_d;
   logic [PC_W-1:0] halt_pc_q, halt_pc_d;

   logic [31:0] pc_ext;
   logic [31:0] pc_imm;
   logic [31:0] pc_four;
   logic [31:0] actual_target;
   logic        actual_taken;
   logic        eff_pred_taken;
   logic [31:0] eff_pred_target;
   logic        mispredict;
   logic        pc_sel;
   logic        flush;
   logic        halted;
   logic [31:0] br_pc;
   logic        btb_upd;

   // Resolution arithmetic: 32-bit, wrapping, with ex_pc zero-extended
   assign pc_ext        = 32'(bp.ex_pc);
   assign pc_imm        = pc_ext + bp.imm;
   assign pc_four       = pc_ext + 32'd4;
   assign actual_taken  = (bp.branch & bp.alu_result[0]) | bp.jal | bp.jalr_sel;
   assign actual_target = bp.jalr_sel ? {bp.alu_result[31:1], 1'b0} : pc_imm;

   assign mispredict = bp.ex_valid &
                       ((actual_taken != eff_pred_taken) |
                        (actual_taken & (actual_target != eff_pred_target)));

   // Halt state and halt PC registers
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q   <= ST_RUN;
         halt_pc_q <= '0;
      end else begin
         state_q   <= state_d;
         halt_pc_q <= halt_pc_d;
      end
   end

   // Next state, redirect outputs and BTB update enable
   always_comb begin
      state_d   = state_q;
      halt_pc_d = halt_pc_q;
      pc_sel    = 1'b0;
      flush     = 1'b0;
      br_pc     = 32'd0;
      halted    = 1'b0;
      btb_upd   = 1'b0;
      case (state_q)
         ST_RUN: begin
            if (bp.ex_valid && bp.halt) begin
               // Halt outranks any mispredict from the same instruction
               pc_sel    = 1'b1;
               flush     = 1'b1;
               br_pc     = pc_ext;
               halt_pc_d = bp.ex_pc;
               state_d   = ST_HALTED;
            end else begin
               btb_upd = bp.ex_valid & (bp.branch | bp.jal | bp.jalr_sel);
               if (mispredict) begin
                  pc_sel = 1'b1;
                  flush  = 1'b1;
                  br_pc  = actual_taken ? actual_target : pc_four;
               end
            end
         end
         ST_HALTED: begin
            pc_sel = 1'b1;
            flush  = 1'b1;
            br_pc  = 32'(halt_pc_q);
            halted = 1'b1;
         end
         default: begin
            state_d = ST_RUN;
         end
      endcase
   end

   assign bp.pc_imm  = pc_imm;
   assign bp.pc_four = pc_four;
   assign bp.br_pc   = br_pc;
   assign bp.pc_sel  = pc_sel;
   assign bp.flush   = flush;
   assign bp.halted  = halted;

`ifdef BRANCH_PREDICT_EN
   localparam int IDX_W = $clog2(BTB_DEPTH);
   localparam int TAG_W = PC_W - IDX_W - 2;
   localparam logic [CTR_W-1:0] CTR_MAX    = '1;
   localparam logic [CTR_W-1:0] CTR_WEAK_T = CTR_W'(1) << (CTR_W - 1);

   logic             valid_q [BTB_DEPTH];
   logic [TAG_W-1:0] tag_q   [BTB_DEPTH];
   logic [31:0]      tgt_q   [BTB_DEPTH];
   logic [CTR_W-1:0] ctr_q   [BTB_DEPTH];

   logic [IDX_W-1:0] if_idx, ex_idx;
   logic [TAG_W-1:0] if_tag, ex_tag;
   logic             if_hit, ex_hit, pred_taken;
   logic [CTR_W-1:0] ex_ctr, ctr_next;
   logic             unused_if_lo;

   assign if_idx = bp.if_pc[IDX_W+1:2];
   assign if_tag = bp.if_pc[PC_W-1:IDX_W+2];
   assign ex_idx = bp.ex_pc[IDX_W+1:2];
   assign ex_tag = bp.ex_pc[PC_W-1:IDX_W+2];

   // The two low PC bits never reach the BTB (word-aligned instructions)
   assign unused_if_lo = ^bp.if_pc[1:0];

   // Lookup reads registered contents only: no bypass of a same-cycle write
   assign if_hit          = valid_q[if_idx] & (tag_q[if_idx] == if_tag);
   assign pred_taken      = if_hit & ctr_q[if_idx][CTR_W-1];
   assign bp.pred_taken   = pred_taken;
   assign bp.pred_target  = pred_taken ? tgt_q[if_idx] : 32'd0;

   assign ex_hit          = valid_q[ex_idx] & (tag_q[ex_idx] == ex_tag);
   assign ex_ctr          = ctr_q[ex_idx];
   assign eff_pred_taken  = bp.ex_pred_taken;
   assign eff_pred_target = bp.ex_pred_target;

   // Saturating counter step toward the resolved direction
   always_comb begin
      ctr_next = ex_ctr;
      if (actual_taken) begin
         if (ex_ctr != CTR_MAX) ctr_next = ex_ctr + CTR_W'(1);
      end else begin
         if (ex_ctr != '0) ctr_next = ex_ctr - CTR_W'(1);
      end
   end

   // BTB storage: train on hit, allocate on taken miss, reset clears all
   always_ff @(posedge clk) begin
      if (!reset) begin
         for (int i = 0; i < BTB_DEPTH; i++) begin
            valid_q[i] <= 1'b0;
            tag_q[i]   <= '0;
            tgt_q[i]   <= '0;
            ctr_q[i]   <= '0;
         end
      end else if (btb_upd) begin
         if (ex_hit) begin
            ctr_q[ex_idx] <= ctr_next;
            if (actual_taken) tgt_q[ex_idx] <= actual_target;
         end else if (actual_taken) begin
            valid_q[ex_idx] <= 1'b1;
            tag_q[ex_idx]   <= ex_tag;
            tgt_q[ex_idx]   <= actual_target;
            ctr_q[ex_idx]   <= CTR_WEAK_T;
         end
      end
   end
`else
   logic unused_cfg;

   // Static not-taken: no storage, carried prediction treated as zero
   assign bp.pred_taken   = 1'b0;
   assign bp.pred_target  = 32'd0;
   assign eff_pred_taken  = 1'b0;
   assign eff_pred_target = 32'd0;
   assign unused_cfg = ^{bp.if_pc, bp.ex_pred_taken, bp.ex_pred_target,
                         btb_upd, 1'(BTB_DEPTH), 1'(CTR_W)};
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// tb_branch_predict_unit
// Directed bench: a vector table for pure resolution behaviour plus
// hand-written sequences for BTB allocation, counter training, aliasing,
// halt and reset. Expectations adapt to the BRANCH_PREDICT_EN build.
`timescale 1ns/1ps
module tb_branch_predict_unit;
   localparam int PC_W = 9;
`ifdef BRANCH_PREDICT_EN
   localparam bit PE = 1'b1;
`else
   localparam bit PE = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   branch_predict_unit_if #(.PC_W(PC_W)) bp();

   branch_predict_unit #(.PC_W(PC_W), .BTB_DEPTH(8), .CTR_W(2)) dut (
      .clk   (clk),
      .reset (reset),
      .bp    (bp)
   );

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic        ex_valid;
      logic [8:0]  ex_pc;
      logic [31:0] imm;
      logic        branch;
      logic [31:0] alu;
      logic        jal;
      logic        jalr;
      logic        pt;
      logic [31:0] ptgt;
      logic        sel_en;
      logic [31:0] br_en;
      logic        sel_dis;
      logic [31:0] br_dis;
      logic [31:0] pimm;
      logic [31:0] pfour;
   } vec_t;

   vec_t vecs [13];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic chk_res(input string nm, input logic sel, input logic [31:0] br);
      chk({nm, ".pc_sel"}, 32'(bp.pc_sel), 32'(sel));
      chk({nm, ".flush"},  32'(bp.flush),  32'(sel));
      chk({nm, ".br_pc"},  bp.br_pc, br);
   endtask

   // Expected prediction given for the predicting build; zero otherwise
   task automatic chk_pred(input string nm, input logic pt, input logic [31:0] tgt);
      chk({nm, ".pred_taken"},  32'(bp.pred_taken), PE ? 32'(pt) : 32'd0);
      chk({nm, ".pred_target"}, bp.pred_target,     PE ? tgt : 32'd0);
   endtask

   task automatic idle();
      bp.ex_valid = 1'b0; bp.ex_pc = '0; bp.imm = '0; bp.branch = 1'b0;
      bp.alu_result = '0; bp.jal = 1'b0; bp.jalr_sel = 1'b0; bp.halt = 1'b0;
      bp.ex_pred_taken = 1'b0; bp.ex_pred_target = '0;
      #1;
   endtask

   task automatic ex_drive(input logic [8:0] pc, input logic [31:0] im,
                           input logic br, input logic [31:0] alu,
                           input logic j, input logic jr, input logic h,
                           input logic pt, input logic [31:0] ptg);
      bp.ex_valid = 1'b1; bp.ex_pc = pc; bp.imm = im; bp.branch = br;
      bp.alu_result = alu; bp.jal = j; bp.jalr_sel = jr; bp.halt = h;
      bp.ex_pred_taken = pt; bp.ex_pred_target = ptg;
      #1;
   endtask

   task automatic look(input logic [8:0] pc);
      bp.if_pc = pc;
      #1;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      //            vld pc      imm           br   alu           jal  jalr pt   ptgt      sel_en br_en      sel_dis br_dis    pimm          pfour
      vecs[0]  = '{1'b1, 9'h100, 32'h10,       1'b1, 32'h1,        1'b0, 1'b0, 1'b0, 32'h0,   1'b1, 32'h110,   1'b1, 32'h110,   32'h110,      32'h104};
      vecs[1]  = '{1'b1, 9'h104, 32'h10,       1'b1, 32'h0,        1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,     1'b0, 32'h0,     32'h114,      32'h108};
      vecs[2]  = '{1'b1, 9'h100, 32'h10,       1'b1, 32'h1,        1'b0, 1'b0, 1'b1, 32'h110, 1'b0, 32'h0,     1'b1, 32'h110,   32'h110,      32'h104};
      vecs[3]  = '{1'b1, 9'h100, 32'h10,       1'b1, 32'h0,        1'b0, 1'b0, 1'b1, 32'h110, 1'b1, 32'h104,   1'b0, 32'h0,     32'h110,      32'h104};
      vecs[4]  = '{1'b1, 9'h1FC, 32'hFFFFFFF0, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h1EC,   1'b1, 32'h1EC,   32'h1EC,      32'h200};
      vecs[5]  = '{1'b1, 9'h020, 32'h0,        1'b0, 32'h101,      1'b0, 1'b1, 1'b1, 32'h80,  1'b1, 32'h100,   1'b1, 32'h100,   32'h20,       32'h24};
      vecs[6]  = '{1'b1, 9'h020, 32'h0,        1'b0, 32'h101,      1'b0, 1'b1, 1'b1, 32'h100, 1'b0, 32'h0,     1'b1, 32'h100,   32'h20,       32'h24};
      vecs[7]  = '{1'b0, 9'h010, 32'h4,        1'b1, 32'h1,        1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,     1'b0, 32'h0,     32'h14,       32'h14};
      vecs[8]  = '{1'b1, 9'h1F0, 32'hFFFFFE20, 1'b0, 32'h0,        1'b1, 1'b0, 1'b0, 32'h0,   1'b1, 32'h10,    1'b1, 32'h10,    32'h10,       32'h1F4};
      vecs[9]  = '{1'b1, 9'h030, 32'h8,        1'b1, 32'h2,        1'b0, 1'b0, 1'b0, 32'h0,   1'b0, 32'h0,     1'b0, 32'h0,     32'h38,       32'h34};
      vecs[10] = '{1'b1, 9'h050, 32'h0,        1'b0, 32'h0,        1'b0, 1'b0, 1'b1, 32'h50,  1'b1, 32'h54,    1'b0, 32'h0,     32'h50,       32'h54};
      vecs[11] = '{1'b1, 9'h040, 32'h20,       1'b1, 32'h1,        1'b0, 1'b0, 1'b1, 32'h64,  1'b1, 32'h60,    1'b1, 32'h60,    32'h60,       32'h44};
      vecs[12] = '{1'b1, 9'h000, 32'h0,        1'b0, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0, 32'h0,   1'b1, 32'hFFFFFFFE, 1'b1, 32'hFFFFFFFE, 32'h0,     32'h4};

      // Reset for two cycles with no EX instruction
      reset = 1'b0;
      bp.if_pc = 9'h040;
      idle();
      repeat (2) @(posedge clk);
      #1;
      chk_res("reset", 1'b0, 32'h0);
      chk("reset.halted", 32'(bp.halted), 32'd0);
      chk("reset.pred_taken", 32'(bp.pred_taken), 32'd0);
      reset = 1'b1;
      $display("reset: pc_sel=%0b br_pc=%h halted=%0b", bp.pc_sel, bp.br_pc, bp.halted);

      // Cold taken branch at 0x40: mispredict, then allocated entry predicts
      ex_drive(9'h040, 32'h20, 1'b1, 32'h1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      look(9'h040);
      chk_pred("cold_lookup", 1'b0, 32'h0);
      chk_res("cold_taken", 1'b1, 32'h60);
      $display("cold branch: pc_sel=%0b br_pc=%h", bp.pc_sel, bp.br_pc);
      tick(); idle(); look(9'h040);
      chk_pred("after_alloc", 1'b1, 32'h60);
      $display("lookup 0x40: pred_taken=%0b target=%h", bp.pred_taken, bp.pred_target);

      // Not taken with correct prior prediction of taken: counter 2->1
      ex_drive(9'h040, 32'h20, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h60);
      chk_res("train_nt1", PE, PE ? 32'h44 : 32'h0);
      $display("train nt1: pc_sel=%0b br_pc=%h", bp.pc_sel, bp.br_pc);
      tick(); idle(); look(9'h040);
      chk_pred("ctr1", 1'b0, 32'h0);
      // Not taken, predicted not taken: counter 1->0, then stays 0
      for (int k = 0; k < 2; k++) begin
         ex_drive(9'h040, 32'h20, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
         chk_res($sformatf("train_nt%0d", k + 2), 1'b0, 32'h0);
         $display("train nt%0d: pc_sel=%0b br_pc=%h", k + 2, bp.pc_sel, bp.br_pc);
         tick();
      end
      idle(); look(9'h040);
      chk_pred("ctr_sat0", 1'b0, 32'h0);

      // Taken twice from 0: needs two steps before predicting taken again
      ex_drive(9'h040, 32'h20, 1'b1, 32'h1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk_res("retrain_t1", 1'b1, 32'h60);
      tick(); idle(); look(9'h040);
      chk_pred("ctr_from0_1", 1'b0, 32'h0);
      ex_drive(9'h040, 32'h20, 1'b1, 32'h1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
      chk_res("retrain_t2", 1'b1, 32'h60);
      tick(); idle(); look(9'h040);
      chk_pred("ctr2_again", 1'b1, 32'h60);
      $display("retrain: pred_taken=%0b target=%h", bp.pred_taken, bp.pred_target);

      // Correctly predicted taken twice (2->3->3), then one not-taken (3->2)
      for (int k = 0; k < 2; k++) begin
         ex_drive(9'h040, 32'h20, 1'b1, 32'h1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h60);
         chk_res($sformatf("t_correct%0d", k), PE ? 1'b0 : 1'b1, PE ? 32'h0 : 32'h60);
         $display("taken correct %0d: pc_sel=%0b", k, bp.pc_sel);
         tick();
      end
      ex_drive(9'h040, 32'h20, 1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h60);
      chk_res("nt_from3", PE, PE ? 32'h44 : 32'h0);
      tick(); idle(); look(9'h040);
      chk_pred("ctr_sat3", 1'b1, 32'h60);
      // 0x60 shares index 0 with 0x40 but has a different tag
      look(9'h060);
      chk_pred("alias_miss", 1'b0, 32'h0);
      $display("alias 0x60: pred_taken=%0b", bp.pred_taken);

      // JALR with wrong predicted target
      ex_drive(9'h024, 32'h0, 1'b0, 32'h101, 1'b0, 1'b1, 1'b0, 1'b1, 32'h80);
      chk_res("jalr_tgt", 1'b1, 32'h100);
      $display("jalr: pc_sel=%0b br_pc=%h", bp.pc_sel, bp.br_pc);
      tick(); idle(); look(9'h024);
      chk_pred("jalr_alloc", 1'b1, 32'h100);

      // Resolution vector table
      for (int i = 0; i < 13; i++) begin
         bp.ex_valid = vecs[i].ex_valid; bp.ex_pc = vecs[i].ex_pc;
         bp.imm = vecs[i].imm; bp.branch = vecs[i].branch;
         bp.alu_result = vecs[i].alu; bp.jal = vecs[i].jal;
         bp.jalr_sel = vecs[i].jalr; bp.halt = 1'b0;
         bp.ex_pred_taken = vecs[i].pt; bp.ex_pred_target = vecs[i].ptgt;
         #1;
         chk_res($sformatf("vec%0d", i), PE ? vecs[i].sel_en : vecs[i].sel_dis,
                 PE ? vecs[i].br_en : vecs[i].br_dis);
         chk($sformatf("vec%0d.pc_imm", i), bp.pc_imm, vecs[i].pimm);
         chk($sformatf("vec%0d.pc_four", i), bp.pc_four, vecs[i].pfour);
         chk($sformatf("vec%0d.halted", i), 32'(bp.halted), 32'd0);
         $display("vec %0d: pc_sel=%0b br_pc=%h pc_imm=%h pc_four=%h",
                  i, bp.pc_sel, bp.br_pc, bp.pc_imm, bp.pc_four);
         tick();
      end

      // Halt with a simultaneous taken branch: halt wins, no BTB write
      ex_drive(9'h088, 32'h10, 1'b1, 32'h1, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
      chk_res("halt_entry", 1'b1, 32'h88);
      chk("halt_entry.halted", 32'(bp.halted), 32'd0);
      $display("halt entry: pc_sel=%0b br_pc=%h", bp.pc_sel, bp.br_pc);
      tick();
      for (int k = 0; k < 3; k++) begin
         case (k)
            0: ex_drive(9'h08C, 32'h10, 1'b1, 32'h1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
            1: ex_drive(9'h010, 32'h0,  1'b0, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
            default: idle();
         endcase
         chk_res($sformatf("halted%0d", k), 1'b1, 32'h88);
         chk($sformatf("halted%0d.halted", k), 32'(bp.halted), 32'd1);
         $display("halted %0d: pc_sel=%0b br_pc=%h halted=%0b", k, bp.pc_sel, bp.br_pc, bp.halted);
         tick();
      end
      idle();
      look(9'h088);
      chk_pred("halt_no_alloc", 1'b0, 32'h0);
      look(9'h08C);
      chk_pred("halted_no_alloc", 1'b0, 32'h0);
      look(9'h024);
      chk_pred("halted_keeps_btb", 1'b1, 32'h100);

      // Reset during a would-be BTB update clears everything
      reset = 1'b0;
      ex_drive(9'h024, 32'h0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
      tick();
      reset = 1'b1;
      idle();
      look(9'h024);
      chk_pred("reset_clears", 1'b0, 32'h0);
      chk("post_reset.halted", 32'(bp.halted), 32'd0);
      chk_res("post_reset", 1'b0, 32'h0);
      $display("post reset: pc_sel=%0b br_pc=%h halted=%0b", bp.pc_sel, bp.br_pc, bp.halted);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Parametrised successor to the EX-stage branch resolver. Adds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, which supplies an IF-stage prediction. EX-stage resolution compares the actual outcome against the prediction carried down the pipeline and raises a redirect/flush only on mispredict. A sticky halt state freezes the PC until reset.

## Interface
Parameters:
- PC_W, 9, width of instruction address; must satisfy PC_W >= IDX_W+3
- BTB_DEPTH, 8, BTB entries; power of two, >= 2; IDX_W = log2(BTB_DEPTH)
- CTR_W, 2, saturating counter width; MSB = predict taken

Ports (reset is synchronous, active-low):
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous active-low reset
- if_pc  in  PC_W  fetch-stage PC
- pred_taken  out  1  IF prediction: BTB hit and counter MSB = 1
- pred_target  out  32  IF predicted target; 0 when pred_taken = 0
- ex_valid  in  1  EX stage holds a valid instruction
- ex_pc  in  PC_W  EX instruction PC
- imm  in  32  EX immediate
- branch  in  1  conditional branch
- alu_result  in  32  ALU output; bit 0 = condition true
- jal  in  1  JAL
- jalr_sel  in  1  JALR; target from alu_result
- halt  in  1  halt instruction
- ex_pred_taken  in  1  prediction made for the EX instruction
- ex_pred_target  in  32  predicted target for the EX instruction
- pc_imm  out  32  {zero-ext ex_pc} + imm
- pc_four  out  32  {zero-ext ex_pc} + 4
- br_pc  out  32  redirect PC
- pc_sel  out  1  1 = take br_pc this cycle
- flush  out  1  kill IF/ID instructions
- halted  out  1  sticky halt state

## Operation
- Arithmetic is 32-bit, wraps mod 2^32; ex_pc zero-extended.
- actual_taken = (branch & alu_result[0]) | jal | jalr_sel.
- actual_target = jalr_sel ? {alu_result[31:1],1'b0} : pc_imm.
- mispredict = ex_valid & (actual_taken != ex_pred_taken | (actual_taken & actual_target != ex_pred_target)).
- RUN state: pc_sel = flush = mispredict; br_pc = actual_taken ? actual_target : pc_four; br_pc = 0 when not redirecting.
- Halt entry: ex_valid & halt in RUN -> pc_sel=1, flush=1, br_pc=ex_pc this cycle. Halt has priority over mispredict. halt_pc <= ex_pc; state -> HALTED.
- HALTED: pc_sel=1, flush=1, br_pc=halt_pc, halted=1. All EX inputs are ignored and no BTB writes occur. The only exit is reset.
- BTB index = pc[IDX_W+1:2]; tag = pc[PC_W-1:IDX_W+2]. Each entry holds valid, tag, 32-bit target and counter.
- Lookup: hit = valid & tag match on if_pc.
- Update on ex_valid & (branch|jal|jalr_sel) & RUN & !halt:
  - hit on ex_pc: counter saturates toward actual_taken (max 2^CTR_W-1, min 0). Target is written when taken.
  - miss and taken: allocate. valid=1, tag, target=actual_target, counter = weakly taken (MSB=1, others 0).
  - miss and not taken: no write.
- Reset: all valid=0, counters=0, targets=0, halt_pc=0, state=RUN. Outputs after reset with ex_valid=0: pc_sel=0, flush=0, br_pc=0, halted=0, pred_taken=0.

## Timing
- All outputs are combinational from current inputs and registered state. Zero-cycle resolution latency.
- A BTB write becomes visible to lookups the following cycle. A same-cycle lookup of the index being written returns the old contents; there is no bypass.
- Reset asserted mid-halt or mid-update overrides everything on that edge.
- Halt entry registers on the edge of the halt cycle; halted=1 from the next cycle.

## Configuration
- BRANCH_PREDICT_EN defined: BTB and counters are built as specified.
- Not defined:
  - no BTB storage; pred_taken=0 and pred_target=0 constantly.
  - resolution is unchanged, so every taken branch/jump mispredicts (static not-taken); ex_pred_* are ignored and treated as 0.

## Test plan
- Reset: reset=0 for 2 cycles -> pred_taken=0, pc_sel=0, flush=0, halted=0, br_pc=0.
- Cold taken branch: ex_pc=0x40, imm=0x20, branch=1, alu_result=1, ex_pred_taken=0 -> pc_sel=1, br_pc=0x60. Next cycle, if_pc=0x40 gives pred_taken=1, pred_target=0x60.
- Counter training: the same branch resolves not-taken twice with a correct prior prediction -> first pc_sel=1, br_pc=0x44, counter 2->1. Then pred_taken=0 for if_pc=0x40; the second resolution (pred 0) gives pc_sel=0 and counter 1->0 (saturated).
- JALR target mismatch: jalr_sel=1, alu_result=0x101, ex_pred_taken=1, ex_pred_target=0x80 -> pc_sel=1, br_pc=0x100.
- Aliasing: 0x40 and 0x60 with BTB_DEPTH=8 share index 0. After training 0x40, if_pc=0x60 -> pred_taken=0 (tag miss).
- Halt: halt=1, ex_valid=1, ex_pc=0x88, plus a simultaneous taken branch -> br_pc=0x88. Thereafter halted=1 and pc_sel=1 with br_pc=0x88 indefinitely; BTB unchanged; reset clears it.
